// File: rtl/riscv_formal_reg_checker_pkg.sv
// Shared types and constants for the RVFI register-consistency checker.
// Register index width is fixed by the RVFI bus format.
package riscv_formal_reg_checker_pkg;

  localparam int REG_IDX_W = 5;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_formal_reg_checker_fwd_stage.sv
// One retire channel: operand compare against the forwarded shadow,
// then this channel's writeback merged into the shadow it passes on.
module riscv_formal_reg_fwd_stage
  import riscv_formal_reg_checker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic [NREGS*XLEN-1:0] shadow_in,
  input  logic [NREGS-1:0]      known_in,
  input  logic                  valid,
  input  logic                  trap,
  input  logic                  check_en,
  input  logic [REG_IDX_W-1:0]  rs1,
  input  logic [REG_IDX_W-1:0]  rs2,
  input  logic [REG_IDX_W-1:0]  rd,
  input  logic [XLEN-1:0]       pre_rs1,
  input  logic [XLEN-1:0]       pre_rs2,
  input  logic [XLEN-1:0]       post_rd,
  output logic [NREGS*XLEN-1:0] shadow_out,
  output logic [NREGS-1:0]      known_out,
  output logic                  chk1,
  output logic                  chk2,
  output logic                  mm1,
  output logic                  mm2,
  output logic [XLEN-1:0]       exp1,
  output logic [XLEN-1:0]       exp2
);

  localparam int IW = $clog2(NREGS);

  logic [IW-1:0] i1, i2, iw;
  logic          oor1, oor2, oorw, wr;

  assign i1   = rs1[IW-1:0];
  assign i2   = rs2[IW-1:0];
  assign iw   = rd[IW-1:0];
  assign oor1 = (rs1 >> IW) != '0;
  assign oor2 = (rs2 >> IW) != '0;
  assign oorw = (rd >> IW) != '0;

  // Reads see shadow_in, so rd == rs reads the pre-write value.
  always_comb begin
    exp1 = '0;
    chk1 = valid && check_en;
    if (rs1 != '0 && !oor1) begin
      if (known_in[i1]) exp1 = shadow_in[i1*XLEN +: XLEN];
      else              chk1 = 1'b0;
    end
    mm1 = chk1 && (oor1 || pre_rs1 != exp1);
  end

  always_comb begin
    exp2 = '0;
    chk2 = valid && check_en;
    if (rs2 != '0 && !oor2) begin
      if (known_in[i2]) exp2 = shadow_in[i2*XLEN +: XLEN];
      else              chk2 = 1'b0;
    end
    mm2 = chk2 && (oor2 || pre_rs2 != exp2);
  end

  assign wr = valid && !trap && rd != '0 && !oorw;

  always_comb begin
    shadow_out = shadow_in;
    known_out  = known_in;
    if (wr) begin
      shadow_out[iw*XLEN +: XLEN] = post_rd;
      known_out[iw]               = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_formal_reg_checker.sv
// Multi-channel RVFI register-consistency checker: shadow register file,
// first-error capture and saturating check counter.
module riscv_formal_reg_checker
  import riscv_formal_reg_checker_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NRET  = 1,
  parameter  int NREGS = 32,
  parameter  int CNT_W = 16,
  localparam int CW    = cw_of(NRET)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET*5-1:0]        rvfi_rs1,
  input  logic [NRET*5-1:0]        rvfi_rs2,
  input  logic [NRET*5-1:0]        rvfi_rd,
  input  logic [NRET*XLEN-1:0]     rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]     rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0]     rvfi_post_rd,
  input  logic [NRET-1:0]          rvfi_post_trap,
  input  logic                     check_en,
  output logic                     err,
  output logic [CW-1:0]            err_chan,
  output logic [REG_IDX_W-1:0]     err_reg,
  output logic [XLEN-1:0]          err_exp,
  output logic [XLEN-1:0]          err_got,
  output logic [CNT_W-1:0]         check_cnt
);

  localparam int SW = CNT_W + 9;

  logic [NREGS*XLEN-1:0] shadow_q;
  logic [NREGS-1:0]      known_q;
  logic [NREGS*XLEN-1:0] sh_c [NRET+1];
  logic [NREGS-1:0]      kn_c [NRET+1];
  logic [NRET-1:0]       chk1, chk2, mm1, mm2;
  logic [XLEN-1:0]       exp1 [NRET];
  logic [XLEN-1:0]       exp2 [NRET];

  assign sh_c[0] = shadow_q;
  assign kn_c[0] = known_q;

  for (genvar c = 0; c < NRET; c++) begin : g_ch
    riscv_formal_reg_fwd_stage #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_stage (
      .shadow_in  (sh_c[c]),
      .known_in   (kn_c[c]),
      .valid      (rvfi_valid[c]),
      .trap       (rvfi_post_trap[c]),
      .check_en   (check_en),
      .rs1        (rvfi_rs1[c*REG_IDX_W +: REG_IDX_W]),
      .rs2        (rvfi_rs2[c*REG_IDX_W +: REG_IDX_W]),
      .rd         (rvfi_rd[c*REG_IDX_W +: REG_IDX_W]),
      .pre_rs1    (rvfi_pre_rs1[c*XLEN +: XLEN]),
      .pre_rs2    (rvfi_pre_rs2[c*XLEN +: XLEN]),
      .post_rd    (rvfi_post_rd[c*XLEN +: XLEN]),
      .shadow_out (sh_c[c+1]),
      .known_out  (kn_c[c+1]),
      .chk1       (chk1[c]),
      .chk2       (chk2[c]),
      .mm1        (mm1[c]),
      .mm2        (mm2[c]),
      .exp1       (exp1[c]),
      .exp2       (exp2[c])
    );
  end

  logic                 hit;
  logic [CW-1:0]        hit_chan;
  logic [REG_IDX_W-1:0] hit_reg;
  logic [XLEN-1:0]      hit_exp, hit_got;
  logic [7:0]           n_chk;
  logic [SW-1:0]        sum;

  // Walk high to low so the lowest channel, rs1 first, is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_chan = '0;
    hit_reg  = '0;
    hit_exp  = '0;
    hit_got  = '0;
    n_chk    = '0;
    for (int c = NRET - 1; c >= 0; c--) begin
      n_chk = n_chk + 8'(chk1[c]) + 8'(chk2[c]);
      if (mm2[c]) begin
        hit      = 1'b1;
        hit_chan = CW'(c);
        hit_reg  = rvfi_rs2[c*REG_IDX_W +: REG_IDX_W];
        hit_exp  = exp2[c];
        hit_got  = rvfi_pre_rs2[c*XLEN +: XLEN];
      end
      if (mm1[c]) begin
        hit      = 1'b1;
        hit_chan = CW'(c);
        hit_reg  = rvfi_rs1[c*REG_IDX_W +: REG_IDX_W];
        hit_exp  = exp1[c];
        hit_got  = rvfi_pre_rs1[c*XLEN +: XLEN];
      end
    end
  end

  assign sum = SW'(check_cnt) + SW'(n_chk);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      known_q   <= '0;
      err       <= 1'b0;
      err_chan  <= '0;
      err_reg   <= '0;
      err_exp   <= '0;
      err_got   <= '0;
      check_cnt <= '0;
    end else begin
      shadow_q <= sh_c[NRET];
      known_q  <= kn_c[NRET];
      if (hit && !err) begin
        err      <= 1'b1;
        err_chan <= hit_chan;
        err_reg  <= hit_reg;
        err_exp  <= hit_exp;
        err_got  <= hit_got;
      end
      if (sum > SW'({CNT_W{1'b1}})) check_cnt <= '1;
      else                          check_cnt <= sum[CNT_W-1:0];
    end
  end

`ifdef FORMAL
  always @(posedge clk) begin
    if (!reset) assert (!(|{mm1, mm2}));
  end
`endif

endmodule

// File: tb/tb_riscv_formal_reg_checker.sv
// Directed scoreboard bench: NRET=2, NREGS=16 (RV32E), 4-bit counter
// so that out-of-range indices and counter saturation are reachable.
module tb_riscv_formal_reg_checker;

  typedef struct packed {
    logic        v;
    logic        trap;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] post;
  } ch_t;

  typedef struct packed {
    int          id;
    logic        err;
    logic        chan;
    logic [4:0]  rg;
    logic [31:0] ex;
    logic [31:0] got;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rvfi_valid, rvfi_post_trap;
  logic [9:0]  rvfi_rs1, rvfi_rs2, rvfi_rd;
  logic [63:0] rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_rd;
  logic        check_en;
  logic        err;
  logic [0:0]  err_chan;
  logic [4:0]  err_reg;
  logic [31:0] err_exp, err_got;
  logic [3:0]  check_cnt;

  riscv_formal_reg_checker #(
    .XLEN(32), .NRET(2), .NREGS(16), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rvfi_valid(rvfi_valid), .rvfi_rs1(rvfi_rs1),
    .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd),
    .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_post_rd(rvfi_post_rd), .rvfi_post_trap(rvfi_post_trap),
    .check_en(check_en), .err(err), .err_chan(err_chan),
    .err_reg(err_reg), .err_exp(err_exp), .err_got(err_got),
    .check_cnt(check_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid   = 0;
  logic en_r  = 1'b1;

  function automatic ch_t mk(logic v, logic t, logic [4:0] a,
                             logic [4:0] b, logic [4:0] d,
                             logic [31:0] p1, logic [31:0] p2,
                             logic [31:0] po);
    ch_t r;
    r.v = v; r.trap = t; r.rs1 = a; r.rs2 = b; r.rd = d;
    r.p1 = p1; r.p2 = p2; r.post = po;
    return r;
  endfunction

  // x15 is never written, so it is a source that is never checked.
  function automatic ch_t wr(logic [4:0] d, logic [31:0] val);
    return mk(1, 0, 15, 15, d, 0, 0, val);
  endfunction

  function automatic ch_t rdv(logic [4:0] s, logic [31:0] val);
    return mk(1, 0, s, 15, 0, val, 0, 0);
  endfunction

  function automatic exp_t ex(logic e, logic c, logic [4:0] r,
                              logic [31:0] x, logic [31:0] g,
                              logic [3:0] n);
    exp_t t;
    t.id = 0; t.err = e; t.chan = c; t.rg = r;
    t.ex = x; t.got = g; t.cnt = n;
    return t;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic drive(ch_t a, ch_t b);
    rvfi_valid     = {b.v, a.v};
    rvfi_post_trap = {b.trap, a.trap};
    rvfi_rs1       = {b.rs1, a.rs1};
    rvfi_rs2       = {b.rs2, a.rs2};
    rvfi_rd        = {b.rd, a.rd};
    rvfi_pre_rs1   = {b.p1, a.p1};
    rvfi_pre_rs2   = {b.p2, a.p2};
    rvfi_post_rd   = {b.post, a.post};
    check_en       = en_r;
  endtask

  task automatic step(ch_t a, ch_t b, exp_t e);
    @(negedge clk);
    drive(a, b);
    vid++;
    e.id = vid;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(string tag);
    cmp({tag, ".err"}, 32'(err), 0);
    cmp({tag, ".chan"}, 32'(err_chan), 0);
    cmp({tag, ".reg"}, 32'(err_reg), 0);
    cmp({tag, ".exp"}, err_exp, 0);
    cmp({tag, ".got"}, err_got, 0);
    cmp({tag, ".cnt"}, 32'(check_cnt), 0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    drive('0, '0);
    drain();
    reset = 1'b1;
    #1;
    chk_zero(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    string p;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        p = $sformatf("v%0d", e.id);
        cmp({p, ".err"}, 32'(err), 32'(e.err));
        cmp({p, ".chan"}, 32'(err_chan), 32'(e.chan));
        cmp({p, ".reg"}, 32'(err_reg), 32'(e.rg));
        cmp({p, ".exp"}, err_exp, e.ex);
        cmp({p, ".got"}, err_got, e.got);
        cmp({p, ".cnt"}, 32'(check_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    ch_t z;
    z = mk(1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive('0, '0);
    #12;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;

    step(wr(5, 32'h1234), '0, ex(0, 0, 0, 0, 0, 0));
    step(rdv(5, 32'h1234), '0, ex(0, 0, 0, 0, 0, 1));

    do_reset("rstB");
    step(wr(7, 32'hAA), mk(1, 0, 15, 7, 0, 0, 32'hAB, 0),
         ex(1, 1, 7, 32'hAA, 32'hAB, 1));
    step('0, '0, ex(1, 1, 7, 32'hAA, 32'hAB, 1));

    do_reset("rstC");
    step(mk(1, 1, 15, 15, 3, 0, 0, 32'h55), '0, ex(0, 0, 0, 0, 0, 0));
    step(rdv(3, 32'h99), '0, ex(0, 0, 0, 0, 0, 0));
    step(rdv(0, 32'h1), '0, ex(1, 0, 0, 0, 1, 1));
    step(wr(2, 32'h10), rdv(2, 32'h11), ex(1, 0, 0, 0, 1, 2));

    do_reset("rstE");
    step(wr(9, 32'h1), wr(9, 32'h2), ex(0, 0, 0, 0, 0, 0));
    step(rdv(9, 32'h2), '0, ex(0, 0, 0, 0, 0, 1));
    step(rdv(9, 32'h1), '0, ex(1, 0, 9, 32'h2, 32'h1, 2));

    do_reset("rstF");
    step(wr(4, 32'h40), wr(6, 32'h60), ex(0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 4, 6, 0, 32'h40, 32'h61, 0),
         mk(1, 0, 4, 15, 0, 32'h41, 0, 0),
         ex(1, 0, 6, 32'h60, 32'h61, 3));

    do_reset("rstG");
    step(rdv(4, 32'h77), '0, ex(0, 0, 0, 0, 0, 0));
    step(wr(8, 32'h1), '0, ex(0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 8, 15, 8, 32'h1, 0, 32'h2), '0, ex(0, 0, 0, 0, 0, 1));
    step(rdv(8, 32'h2), '0, ex(0, 0, 0, 0, 0, 2));
    step(wr(20, 32'h5), '0, ex(0, 0, 0, 0, 0, 2));
    step(rdv(20, 32'h5), '0, ex(1, 0, 20, 0, 32'h5, 3));

    do_reset("rstI");
    en_r = 1'b0;
    step(wr(10, 32'hA), '0, ex(0, 0, 0, 0, 0, 0));
    step(rdv(10, 32'hB), '0, ex(0, 0, 0, 0, 0, 0));
    en_r = 1'b1;
    step(rdv(10, 32'hA), '0, ex(0, 0, 0, 0, 0, 1));
    step(z, z, ex(0, 0, 0, 0, 0, 5));
    step(z, z, ex(0, 0, 0, 0, 0, 9));
    step(z, z, ex(0, 0, 0, 0, 0, 13));
    step(z, z, ex(0, 0, 0, 0, 0, 15));
    step(z, z, ex(0, 0, 0, 0, 0, 15));

    @(negedge clk);
    drive('0, '0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
